// File: rtl/deser_pkg.sv
// Shared constants for the frame deserializer:
// state encoding, bit-order modes and counter sizing.
package deser_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_hold.sv
// Output holding register for completed frames with
// valid/ready handshake and sticky overrun on dropped words.
module deser_hold #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             hs;
  logic             drop;

  always_comb begin
    hs        = valid_q & ready;
    drop      = load & valid_q & ~ready;
    dout_d    = dout_q;
    valid_d   = valid_q;
    if (load && !drop) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    // a new drop beats a same-cycle clear
    overrun_d = drop | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/deser_frame.sv
// Serial-to-parallel frame assembler with per-frame length
// and bit order, feeding a single-entry holding register.
module deser_frame
  import deser_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             si,
  input  logic [CNT_W-1:0] len,
  input  logic             lsb_first,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] flen_q, flen_d;
  logic             fmode_q, fmode_d;

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] frame_len;
  logic [CNT_W-1:0] bit_num;
  logic [WIDTH-1:0] word;
  logic             done;

  always_comb begin
    len_eff   = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
    state_d   = state_q;
    count_d   = count_q;
    sreg_d    = sreg_q;
    flen_d    = flen_q;
    fmode_d   = fmode_q;
    frame_len = flen_q;
    bit_num   = count_q + 1'b1;
    word      = sreg_q;
    done      = 1'b0;
    if (sync) begin
      state_d = ST_IDLE;
      count_d = '0;
      sreg_d  = '0;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          // first bit sits at bit 0 in either order
          frame_len = len_eff;
          flen_d    = len_eff;
          fmode_d   = lsb_first;
          bit_num   = CNT_W'(1);
          word      = WIDTH'(si);
        end
        ST_SHIFT: begin
          if (fmode_q == LSB_FIRST) begin
            word = sreg_q | (WIDTH'(si) << count_q);
          end else begin
            word = {sreg_q[WIDTH-2:0], si};
          end
        end
      endcase
      done    = bit_num == frame_len;
      state_d = done ? ST_IDLE : ST_SHIFT;
      count_d = done ? '0 : bit_num;
      sreg_d  = done ? '0 : word;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sreg_q  <= '0;
      flen_q  <= '0;
      fmode_q <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sreg_q  <= sreg_d;
      flen_q  <= flen_d;
      fmode_q <= fmode_d;
    end
  end

  assign busy = state_q == ST_SHIFT;

  deser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .clr        (clr),
    .load       (done),
    .word       (word),
    .ready      (dout_ready),
    .overrun_clr(overrun_clr),
    .dout       (dout),
    .valid      (dout_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_deser_frame.sv
// Bench for deser_frame: directed frames plus random traffic
// against a queue-based frame model.
module tb_deser_frame;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          enable;
  logic          si;
  logic [CW-1:0] len;
  logic          lsb_first;
  logic          sync;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          overrun;
  logic          overrun_clr;

  int checks = 0;
  int errors = 0;

  int         m_bits[$];
  int         m_len;
  bit         m_mode;
  bit         m_busy;
  bit         m_valid;
  bit         m_ovr;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  deser_frame #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .enable     (enable),
    .si         (si),
    .len        (len),
    .lsb_first  (lsb_first),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // first received bit is bit 0 (lsb) or bit len-1 (msb)
  function automatic logic [W-1:0] pack();
    int val;
    val = 0;
    for (int i = 0; i < m_bits.size(); i++)
      if (m_bits[i] != 0)
        val += 1 << (m_mode ? i : m_len - 1 - i);
    return W'(val);
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_len   = W;
    m_mode  = 1'b0;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dout  = '0;
  endtask

  task automatic model_step();
    bit           done;
    bit           hs;
    bit           ovf;
    int           l;
    logic [W-1:0] w;
    done = 1'b0;
    w    = '0;
    hs   = m_valid && dout_ready;
    if (sync) begin
      m_bits.delete();
      m_busy = 1'b0;
    end else if (enable) begin
      if (!m_busy) begin
        l      = int'(len);
        m_len  = (l == 0 || l > W) ? W : l;
        m_mode = lsb_first;
        m_busy = 1'b1;
        m_bits.delete();
      end
      m_bits.push_back(int'(si));
      if (m_bits.size() == m_len) begin
        w    = pack();
        done = 1'b1;
        m_bits.delete();
        m_busy = 1'b0;
      end
    end
    ovf = done && m_valid && !dout_ready;
    if (done && !ovf) begin
      m_dout  = w;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    m_ovr = ovf || (m_ovr && !overrun_clr);
  endtask

  task automatic cyc(input bit en, input bit b, input bit sy,
                     input bit rdy, input bit oc);
    enable      = en;
    si          = b;
    sync        = sy;
    dout_ready  = rdy;
    overrun_clr = oc;
    model_step();
    @(posedge clk);
    #1;
    chk("dout", 64'(dout), 64'(m_dout));
    chk("valid", 64'(dout_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("ovr", 64'(overrun), 64'(m_ovr));
  endtask

  // bits go out v[n-1] first
  task automatic send(input logic [7:0] v, input int n, input bit mode,
                      input int ln, input bit rdy, input bit rdy_last);
    len       = CW'(ln);
    lsb_first = mode;
    for (int i = n - 1; i >= 0; i--)
      cyc(1'b1, v[i], 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic consume();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_clr();
    enable      = 1'b0;
    sync        = 1'b0;
    dout_ready  = 1'b0;
    overrun_clr = 1'b0;
    clr         = 1'b1;
    #2;
    chk("clr_dout", 64'(dout), 64'h0);
    chk("clr_valid", 64'(dout_valid), 64'h0);
    chk("clr_busy", 64'(busy), 64'h0);
    chk("clr_ovr", 64'(overrun), 64'h0);
    model_reset();
    #2;
    clr = 1'b0;
  endtask

  initial begin
    clr         = 1'b1;
    enable      = 1'b0;
    si          = 1'b0;
    sync        = 1'b0;
    dout_ready  = 1'b0;
    overrun_clr = 1'b0;
    len         = '0;
    lsb_first   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ovr", 64'(overrun), 64'h0);
    clr = 1'b0;

    send(8'hB2, 8, 1'b0, 8, 1'b0, 1'b0);
    chk("b2_msb", 64'(dout), 64'hB2);
    chk("b2_valid", 64'(dout_valid), 64'h1);
    chk("b2_busy", 64'(busy), 64'h0);
    consume();
    chk("b2_taken", 64'(dout_valid), 64'h0);

    send(8'hB2, 8, 1'b1, 8, 1'b0, 1'b0);
    chk("b2_lsb", 64'(dout), 64'h4D);
    consume();
    send(8'h0D, 4, 1'b0, 4, 1'b0, 1'b0);
    chk("len4_msb", 64'(dout), 64'h0D);
    consume();
    send(8'h0D, 4, 1'b1, 4, 1'b0, 1'b0);
    chk("len4_lsb", 64'(dout), 64'h0B);
    consume();

    send(8'hB2, 8, 1'b0, 8, 1'b0, 1'b0);
    send(8'h4D, 8, 1'b0, 8, 1'b0, 1'b0);
    chk("ovr_dout", 64'(dout), 64'hB2);
    chk("ovr_set", 64'(overrun), 64'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 64'(overrun), 64'h0);
    consume();

    send(8'hB2, 8, 1'b0, 8, 1'b0, 1'b0);
    send(8'h4D, 8, 1'b0, 8, 1'b0, 1'b1);
    chk("hs_dout", 64'(dout), 64'h4D);
    chk("hs_valid", 64'(dout_valid), 64'h1);
    chk("hs_ovr", 64'(overrun), 64'h0);
    consume();

    send(8'h05, 3, 1'b0, 8, 1'b0, 1'b0);
    do_clr();
    send(8'hA5, 8, 1'b0, 8, 1'b0, 1'b0);
    chk("clr_a5", 64'(dout), 64'hA5);
    consume();

    send(8'hB2, 8, 1'b0, 8, 1'b0, 1'b0);
    send(8'h05, 3, 1'b0, 8, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_busy", 64'(busy), 64'h0);
    chk("sync_keep", 64'(dout), 64'hB2);
    send(8'h52, 7, 1'b0, 8, 1'b0, 1'b0);
    chk("sync_held", 64'(dout), 64'hB2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sync_a5", 64'(dout), 64'hA5);
    chk("sync_ovr", 64'(overrun), 64'h0);
    consume();

    send(8'hC3, 8, 1'b0, 0, 1'b0, 1'b0);
    chk("len0", 64'(dout), 64'hC3);
    consume();
    send(8'hE0, 8, 1'b1, 12, 1'b0, 1'b0);
    chk("len12", 64'(dout), 64'h07);
    consume();
    send(8'h01, 1, 1'b0, 1, 1'b0, 1'b0);
    chk("len1", 64'(dout), 64'h01);
    chk("len1_busy", 64'(busy), 64'h0);
    consume();

    len       = 4'd4;
    lsb_first = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    len       = 4'd8;
    lsb_first = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("len_locked", 64'(dout), 64'h0D);
    consume();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_clr();
      end else begin
        len       = CW'($urandom_range(0, 15));
        lsb_first = 1'($urandom_range(0, 1));
        cyc($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deser_frame.md
DESER_FRAME -- requirements
Module: deser_frame

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the maximum frame length in bits and the dout width.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), SHALL set the width of the bit counter and the len port.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 clr  input  1  reset: asynchronous, active-high.
REQ-005 enable  input  1  bit strobe; si SHALL be sampled on each clk edge where enable=1.
REQ-006 si  input  1  serial data in.
REQ-007 len  input  CNT_W  frame length in bits, 1..WIDTH; 0 or values above WIDTH SHALL be treated as WIDTH.
REQ-008 lsb_first  input  1  bit-order mode: 1 = first bit lands in bit 0; 0 = first bit lands in bit len-1.
REQ-009 sync  input  1  synchronous frame abort/restart.
REQ-010 dout  output  WIDTH  assembled frame; bits at len and above SHALL be 0.
REQ-011 dout_valid  output  1  dout holds an unconsumed frame.
REQ-012 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-013 busy  output  1  a frame is partially received (state SHIFT).
REQ-014 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-015 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-016 The FSM SHALL have two states: IDLE (count=0) and SHIFT (count 1..len-1).
REQ-017 IDLE + enable: the block SHALL latch len and lsb_first into frame-local registers, store si as bit 1 of the frame, and go to SHIFT; if the latched len=1, the frame SHALL complete on that edge.
REQ-018 SHIFT + enable: the block SHALL store si and increment count; when the bit stored is bit number len, the frame SHALL complete, count SHALL return to 0 and the state SHALL go to IDLE on the same edge.
REQ-019 Changes to len or lsb_first while in SHIFT SHALL have no effect on the current frame.
REQ-020 MSB-first mode: the shift register SHALL shift left with si entering at bit 0, so the last bit ends in bit 0.
REQ-021 LSB-first mode: si SHALL be written at bit index count, so the last bit ends in bit len-1.
REQ-022 On frame completion the word SHALL be transferred to the holding register, and dout_valid SHALL be 1 in the cycle after the edge that captured the last bit (latency 1).
REQ-023 Shifting of the next frame SHALL continue while the holding register is valid; there SHALL be no stall on enable.
REQ-024 Completion with dout_valid=1 and dout_ready=0: the new word SHALL be dropped, dout SHALL stay unchanged, and overrun SHALL set to 1.
REQ-025 Completion in the same cycle as a handshake (valid and ready both 1): the new word SHALL load, dout_valid SHALL stay 1, and overrun SHALL not set.
REQ-026 A handshake with no completion SHALL clear dout_valid; dout SHALL hold its last value.
REQ-027 sync=1 SHALL clear count, the shift register and busy, and return to IDLE; the bit on enable in that cycle SHALL be discarded (sync has priority over enable); the holding register and dout_valid SHALL be unaffected.
REQ-028 If overrun_clr and a new overrun occur in the same cycle, overrun SHALL be 1 (set wins).

Reset
REQ-029 clr=1 SHALL immediately force state IDLE, count=0, shift register=0, dout=0, dout_valid=0, busy=0, overrun=0, and clear the latched len/mode, regardless of clk.
REQ-030 Assertion of clr mid-frame SHALL discard the partial frame; the first enable after clr deasserts SHALL start a new frame.

Structure
REQ-031 Package deser_pkg SHALL hold the IDLE/SHIFT state encoding, the mode constants MSB_FIRST=0 and LSB_FIRST=1, and the CNT_W width function.
REQ-032 The holding register with its valid/ready/overrun logic SHALL be a sub-module, deser_hold, parametrised by WIDTH.

Verification
REQ-033 WIDTH=8, len=8, lsb_first=0, bits 1,0,1,1,0,0,1,0 on consecutive enables -> dout=8'hB2, dout_valid=1 one cycle after the 8th bit, busy=0.
REQ-034 Same bits with lsb_first=1 -> dout=8'h4D; len=4, bits 1,1,0,1 -> dout=8'h0D (MSB-first) and 8'h0B (LSB-first).
REQ-035 dout_ready=0, two 8-bit frames 8'hB2 then 8'h4D -> dout stays 8'hB2, overrun=1; overrun_clr pulse -> overrun=0.
REQ-036 dout_ready=1 asserted exactly on the completion edge of a second frame -> dout changes 8'hB2 to 8'h4D, dout_valid stays 1, overrun=0.
REQ-037 clr pulse after 3 bits, then 8 bits of 8'hA5 -> all outputs 0 during clr, then dout=8'hA5; repeat using sync instead of clr -> same dout, and a prior valid word is retained until consumed.
